// File: rtl/bin2bcd_seq_if.sv
// bin2bcd_seq_if: handshake/result bundle for bin2bcd_seq.
// Ports: din/din_valid (request), din_ready (accept), bcd/ovf/done (result).
// master = value source, slave = converter.
interface bin2bcd_seq_if;
  logic [15:0] din;
  logic        din_valid;
  logic        din_ready;
  logic [15:0] bcd;
  logic        ovf;
  logic        done;
  modport master (output din, din_valid, input din_ready, bcd, ovf, done);
  modport slave (input din, din_valid, output din_ready, bcd, ovf, done);
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential 16-bit binary to 4-digit packed BCD, one double-dabble step per clock.
// Ports: clk, reset_b (sync, active-low), io (slave: din/din_valid in; din_ready/bcd/ovf/done out).
module bin2bcd_seq #(
  parameter bit HEX_FALLBACK = 1'b1
) (
  input logic         clk,
  input logic         reset_b,
  bin2bcd_seq_if.slave io
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t      state_q, state_d;
  logic [15:0] sh_q, sh_d, hold_q, hold_d, bcd_q, bcd_d;
  logic [19:0] acc_q, acc_d, adj, acc_nx;
  logic [4:0]  cnt_q, cnt_d;
  logic        ovf_q, ovf_d, done_q, done_d, ovf_nx;
  // add-3 on every digit >= 5, all five in parallel, ahead of the shift
  for (genvar d = 0; d < 5; d++) begin : g_adj
    assign adj[4*d+:4] = acc_q[4*d+:4] + (acc_q[4*d+:4] >= 4'd5 ? 4'd3 : 4'd0);
  end
  assign acc_nx = {adj[18:0], sh_q[15]};
  assign ovf_nx = |acc_nx[19:16];
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    hold_d  = hold_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (io.din_valid) begin
        state_d = SHIFT;
        sh_d    = io.din;
        hold_d  = io.din;
        acc_d   = '0;
        cnt_d   = '0;
      end
    end else begin
      acc_d = acc_nx;
      sh_d  = {sh_q[14:0], 1'b0};
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == 5'd15) begin
        state_d = IDLE;
        ovf_d   = ovf_nx;
        bcd_d   = (ovf_nx && HEX_FALLBACK) ? hold_q : acc_nx[15:0];
        done_d  = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state_q <= IDLE;
      sh_q    <= '0;
      hold_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      hold_q  <= hold_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end
  assign io.din_ready = state_q == IDLE;
  assign io.bcd       = bcd_q;
  assign io.ovf       = ovf_q;
  assign io.done      = done_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: random and directed checks of bin2bcd_seq (both fallback modes) against a transaction-level model.
module tb_bin2bcd_seq;
  logic        clk = 1'b0;
  logic        reset_b = 1'b0;
  logic [15:0] din = '0;
  logic        din_valid = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;
  bin2bcd_seq_if io1 ();
  bin2bcd_seq_if io0 ();
  assign io1.din = din;
  assign io1.din_valid = din_valid;
  assign io0.din = din;
  assign io0.din_valid = din_valid;
  bin2bcd_seq #(.HEX_FALLBACK(1'b1)) dut1 (.clk(clk), .reset_b(reset_b), .io(io1));
  bin2bcd_seq #(.HEX_FALLBACK(1'b0)) dut0 (.clk(clk), .reset_b(reset_b), .io(io0));
  always #5 clk = ~clk;
  function automatic logic [15:0] conv(int v, bit hf);
    int n;
    if (v > 9999 && hf) return 16'(v);
    n = v % 10000;
    return {4'(n / 1000), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // model: a conversion occupies 16 cycles after accept, then publishes its result for one done cycle
  int          busy = 0;
  logic [15:0] pend = '0, res = '0;
  logic        exp_done = 1'b0;
  bit          armed = 1'b0;
  always @(posedge clk) begin
    if (!reset_b) begin
      busy = 0;
      res = '0;
      exp_done = 1'b0;
      armed = 1'b1;
    end else if (busy == 0) begin
      exp_done = 1'b0;
      if (din_valid) begin
        busy = 16;
        pend = din;
      end
    end else begin
      busy--;
      exp_done = busy == 0;
      if (busy == 0) res = pend;
    end
  end
  always @(negedge clk) begin
    if (armed) begin
      chk("ready1", 32'(io1.din_ready), 32'(busy == 0));
      chk("ready0", 32'(io0.din_ready), 32'(busy == 0));
      chk("done1", 32'(io1.done), 32'(exp_done));
      chk("done0", 32'(io0.done), 32'(exp_done));
      chk("bcd1", 32'(io1.bcd), 32'(conv(res, 1'b1)));
      chk("bcd0", 32'(io0.bcd), 32'(conv(res, 1'b0)));
      chk("ovf1", 32'(io1.ovf), 32'(res > 16'd9999));
      chk("ovf0", 32'(io0.ovf), 32'(res > 16'd9999));
    end
  end
  task automatic expect_done(logic [15:0] b1, logic o1, logic [15:0] b0, logic o0);
    bit seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      seen = io1.done;
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got no done expected done within 40 cycles at %0t", $time);
    end else begin
      chk("lit_bcd1", 32'(io1.bcd), 32'(b1));
      chk("lit_ovf1", 32'(io1.ovf), 32'(o1));
      chk("lit_bcd0", 32'(io0.bcd), 32'(b0));
      chk("lit_ovf0", 32'(io0.ovf), 32'(o0));
    end
  endtask
  task automatic conv_one(logic [15:0] v, logic [15:0] b1, logic o1, logic [15:0] b0, logic o0);
    @(negedge clk);
    din = v;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    din = $urandom;
    expect_done(b1, o1, b0, o0);
  endtask
  initial begin
    chk("model_1234", 32'(conv(1234, 1'b1)), 32'h1234);
    chk("model_65535", 32'(conv(65535, 1'b0)), 32'h5535);
    chk("model_10000h", 32'(conv(10000, 1'b1)), 32'h2710);
    chk("model_10000b", 32'(conv(10000, 1'b0)), 32'h0000);
    repeat (2) @(negedge clk);
    chk("rst_bcd", 32'(io1.bcd), 32'h0);
    chk("rst_ready", 32'(io1.din_ready), 32'h1);
    reset_b = 1'b1;
    conv_one(16'd1234, 16'h1234, 1'b0, 16'h1234, 1'b0);
    conv_one(16'd0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    conv_one(16'd9999, 16'h9999, 1'b0, 16'h9999, 1'b0);
    conv_one(16'd10000, 16'h2710, 1'b1, 16'h0000, 1'b1);
    conv_one(16'd65535, 16'hFFFF, 1'b1, 16'h5535, 1'b1);
    @(negedge clk);
    din = 16'd42;
    din_valid = 1'b1;
    fork
      repeat (36) begin
        @(negedge clk);
        din = (din == 16'd42) ? 16'd8765 : 16'd42;
      end
      begin
        expect_done(16'h0042, 1'b0, 16'h0042, 1'b0);
        expect_done(16'h8765, 1'b0, 16'h8765, 1'b0);
      end
    join
    din_valid = 1'b0;
    repeat (20) @(negedge clk);
    @(negedge clk);
    din = 16'd5555;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    repeat (7) @(negedge clk);
    reset_b = 1'b0;
    @(negedge clk);
    reset_b = 1'b1;
    chk("abort_bcd", 32'(io1.bcd), 32'h0);
    chk("abort_ovf", 32'(io1.ovf), 32'h0);
    chk("abort_ready", 32'(io1.din_ready), 32'h1);
    repeat (20) @(negedge clk);
    conv_one(16'd777, 16'h0777, 1'b0, 16'h0777, 1'b0);
    conv_one(16'd1111, 16'h1111, 1'b0, 16'h1111, 1'b0);
    conv_one(16'd4321, 16'h4321, 1'b0, 16'h4321, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      din = ($urandom % 2) ? 16'($urandom) : 16'($urandom % 10000);
      din_valid = ($urandom % 4) == 0;
      reset_b = ($urandom % 300) != 0;
    end
    reset_b = 1'b1;
    din_valid = 1'b0;
    repeat (20) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
